fifo_fwft_unpacker: RTL and testbench

- Drains a first-word-fall-through FIFO read port (dout/empty/rden) and serialises each wide FIFO word into narrower beats on a valid/ready master stream.
- Sits downstream of the wide datapath FIFOs and feeds narrow consumers such as the AXI-stream egress and the configuration loaders.
- Acts as the reader-side counterpart of the FIFO write path.
- Sustains one output beat per cycle with no bubble between FIFO words.

---
 rtl/fifo_fwft_unpacker.sv | 63 ++++++
 tb/tb_fifo_fwft_unpacker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_unpacker.sv
// fifo_fwft_unpacker: drains an FWFT FIFO read port and serialises each wide word into narrow valid/ready beats (optional packet framing with FIFO_UNPACK_LAST_EN)
module fifo_fwft_unpacker #(
    parameter int C_IN_WIDTH      = 128,
    parameter int C_OUT_WIDTH     = 32,
    parameter int C_PKT_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_IN_WIDTH-1:0]  fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rden,
    output logic [C_OUT_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy
`ifdef FIFO_UNPACK_LAST_EN
    ,
    input  logic [C_PKT_CNT_WIDTH-1:0] cfg_pkt_beats,
    output logic                       m_last
`endif
);
    localparam int C_RATIO     = C_IN_WIDTH / C_OUT_WIDTH;
    localparam int C_IDX_WIDTH = C_RATIO > 1 ? $clog2(C_RATIO) : 1;
    logic [C_IN_WIDTH-1:0]  hold_r;
    logic [C_IDX_WIDTH-1:0] idx;
    logic                   accept;
    logic                   last_slice;
    assign accept     = m_valid & m_ready;
    assign last_slice = idx == C_IDX_WIDTH'(C_RATIO - 1);
    assign fifo_rden  = ~rst & ~fifo_empty & (~m_valid | (accept & last_slice));
    assign m_data     = hold_r[idx*C_OUT_WIDTH +: C_OUT_WIDTH];
    assign busy       = m_valid;
    // Holding register loads only on a pop; left unreset since m_valid qualifies it
    always_ff @(posedge clk) begin
        if (fifo_rden) hold_r <= fifo_dout;
    end
    // Slice index and valid: refill on pop, step on accept, go idle after the last slice
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            idx     <= '0;
        end else if (fifo_rden) begin
            m_valid <= 1'b1;
            idx     <= '0;
        end else if (accept & ~last_slice) begin
            idx <= idx + 1'b1;
        end else if (accept) begin
            m_valid <= 1'b0;
            idx     <= '0;
        end
    end
`ifdef FIFO_UNPACK_LAST_EN
    logic [C_PKT_CNT_WIDTH-1:0] beat_cnt;
    logic                       pkt_end;
    assign pkt_end = (cfg_pkt_beats == '0) | (beat_cnt == cfg_pkt_beats - 1'b1);
    assign m_last  = m_valid & pkt_end;
    // Packet beat counter, independent of FIFO word boundaries
    always_ff @(posedge clk) begin
        if (rst) beat_cnt <= '0;
        else if (accept) beat_cnt <= pkt_end ? '0 : beat_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_fwft_unpacker.sv
// tb_fifo_fwft_unpacker: FIFO model plus beat scoreboard and cycle vector table for fifo_fwft_unpacker
module tb_fifo_fwft_unpacker;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] fifo_dout = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rden;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         busy;
`ifdef FIFO_UNPACK_LAST_EN
    logic [15:0]  cfg_pkt_beats = 16'd6;
    logic         m_last;
`endif

    fifo_fwft_unpacker dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rden(fifo_rden), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy)
`ifdef FIFO_UNPACK_LAST_EN
        , .cfg_pkt_beats(cfg_pkt_beats), .m_last(m_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int i; } beat_t;
    typedef struct { logic rdy; logic v; logic [31:0] d; logic r; } vec_t;

    logic [127:0] fifo_q[$];
    beat_t        exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           rden_n = 0;
    int           beat_n = 0;
    logic         last_on = 1'b0;
    logic         s_rden, s_valid;
    logic [31:0]  s_data;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic upd();
        fifo_empty = fifo_q.size() == 0;
        fifo_dout  = fifo_q.size() > 0 ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [127:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back('{w[i*32 +: 32], i});
        fifo_q.push_back(w);
        upd();
    endtask

    task automatic tick();
        beat_t e;
        @(negedge clk);
        s_rden  = fifo_rden;
        s_valid = m_valid;
        s_data  = m_data;
        chk("rden_when_empty", fifo_rden & fifo_empty, 0);
        chk("busy", busy, m_valid);
        if (rst) chk("rden_in_rst", fifo_rden, 0);
        if (fifo_rden) rden_n++;
        if (m_valid && !m_ready) chk("rden_stall", fifo_rden, 0);
        if (m_valid && m_ready && !rst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %h want none", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat", m_data, e.d);
                if (fifo_rden) chk("rden_slice", e.i, 3);
`ifdef FIFO_UNPACK_LAST_EN
                if (last_on) begin
                    beat_n++;
                    chk("m_last", m_last, (beat_n % 6) == 0);
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        if (s_rden && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            upd();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
        chk("drain_left", exp_q.size(), 0);
        tick();
        chk("idle_valid", s_valid, 0);
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b1};
        tbl[1] = '{1'b1, 1'b1, 32'h11111111, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h22222222, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h33333333, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h44444444, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h0,        1'b0};

        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst_idle_rden", s_rden, 0);
            chk("rst_idle_valid", s_valid, 0);
        end

        push_word(128'h44444444_33333333_22222222_11111111);
        for (int i = 0; i < 6; i++) begin
            m_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].v);
            chk($sformatf("vec%0d_rden", i), s_rden, tbl[i].r);
            if (tbl[i].v) chk($sformatf("vec%0d_data", i), s_data, tbl[i].d);
        end

        rden_n = 0;
        push_word(128'h0c0c0c0c_0b0b0b0b_0a0a0a0a_09090909);
        push_word(128'h1c1c1c1c_1b1b1b1b_1a1a1a1a_19191919);
        push_word(128'h2c2c2c2c_2b2b2b2b_2a2a2a2a_29292929);
        tick();
        chk("burst_first_rden", s_rden, 1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("burst_valid%0d", k), s_valid, 1);
        end
        drain();
        chk("burst_rden_count", rden_n, 3);

        push_word(128'h44444444_33333333_22222222_11111111);
        push_word(128'h88888888_77777777_66666666_55555555);
        repeat (3) tick();
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", s_data, 32'h33333333);
            chk("stall_valid", s_valid, 1);
            chk("stall_rden", s_rden, 0);
        end
        m_ready = 1'b1;
        drain();

        push_word(128'h0d0d0d0d_0c0c0c0c_0b0b0b0b_0a0a0a0a);
        push_word(128'hf4f4f4f4_f3f3f3f3_f2f2f2f2_f1f1f1f1);
        repeat (3) tick();
        exp_q.delete(0);
        exp_q.delete(0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", s_valid, 0);
        chk("post_rst_rden", s_rden, 1);
        tick();
        chk("post_rst_slice0", s_data, 32'hf1f1f1f1);
        drain();

`ifdef FIFO_UNPACK_LAST_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_on = 1'b1;
        beat_n = 0;
        push_word(128'h04040404_03030303_02020202_01010101);
        push_word(128'h08080808_07070707_06060606_05050505);
        push_word(128'h0c0c0c0c_0b0b0b0b_0a0a0a0a_09090909);
        drain();
        chk("last_beat_count", beat_n, 12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
